fetch_prefetch_queue: RTL and testbench



---
 rtl/fetch_prefetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: in-order requests to a variable-latency memory,
// a DEPTH-entry tagged queue toward decode, redirect flush with stale squashing, sticky halt.
module fetch_prefetch_queue #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        PC_STEP  = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req_valid,
    output logic [ADDR_W-1:0]            imem_req_addr,
    input  logic                         imem_req_ready,
    input  logic                         imem_rsp_valid,
    input  logic [INSTR_W-1:0]           imem_rsp_data,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    output logic                         dec_valid,
    output logic [INSTR_W-1:0]           dec_instr,
    output logic [ADDR_W-1:0]            dec_pc,
    output logic [ADDR_W-1:0]            dec_nxt_pc,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted
);
    // state  | meaning
    // FETCH  | issuing requests whenever space and no stale responses pending
    // HALTED | no new requests; queued/outstanding work still drains
    typedef enum logic {FETCH, HALTED} state_t;

    localparam int unsigned       PTR_W = $clog2(DEPTH);
    localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [PTR_W:0]     head, fill, tail, discard_cnt;
    logic [PTR_W:0]     occupancy, outstanding, discard_nxt;
    logic               accept, rsp_live, rsp_drop, pop;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    assign occupancy   = tail - head;
    assign outstanding = tail - fill;
    assign count       = CNT_W'(occupancy);
    assign halted      = (state_q == HALTED);

    // Held low during reset so the memory never sees a request before release.
    assign imem_req_valid = rst_n & (state_q == FETCH) & ~redirect & ~halt
                          & (occupancy < FULL) & (discard_cnt == '0);
    assign imem_req_addr  = fetch_pc;

    assign accept   = imem_req_valid & imem_req_ready;
    assign rsp_drop = imem_rsp_valid & (discard_cnt != '0);
    assign rsp_live = imem_rsp_valid & (discard_cnt == '0) & (fill != tail);
    assign dec_valid = (head != fill);
    assign pop       = dec_valid & dec_ready;

    // Every request still owed a response after a redirect becomes a discard.
    assign discard_nxt = outstanding + discard_cnt
                       - {{PTR_W{1'b0}}, rsp_live} - {{PTR_W{1'b0}}, rsp_drop};

    assign dec_pc     = dec_valid ? pc_mem[head[PTR_W-1:0]]    : '0;
    assign dec_instr  = dec_valid ? instr_mem[head[PTR_W-1:0]] : '0;
    assign dec_nxt_pc = dec_valid ? pc_mem[head[PTR_W-1:0]] + STEP : '0;

    always_comb begin
        state_d = state_q;
        if (redirect)
            state_d = FETCH;
        else if (state_q == FETCH && halt)
            state_d = HALTED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            fill        <= '0;
            tail        <= '0;
            discard_cnt <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            head        <= tail;
            fill        <= tail;
            discard_cnt <= discard_nxt;
        end else begin
            if (accept) begin
                tail     <= tail + 1'b1;
                fetch_pc <= fetch_pc + STEP;
            end
            if (rsp_live)
                fill <= fill + 1'b1;
            if (rsp_drop)
                discard_cnt <= discard_cnt - 1'b1;
            if (pop)
                head <= head + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pc_mem[tail[PTR_W-1:0]] <= fetch_pc;
        if (rsp_live && !redirect)
            instr_mem[fill[PTR_W-1:0]] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus random traffic against
// a transaction-level model (in-flight request list and ready-to-decode list).
module tb_fetch_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [15:0] dec_nxt_pc;
    logic        dec_ready;
    logic [2:0]  count;
    logic        halted;

    fetch_prefetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_nxt_pc(dec_nxt_pc), .dec_ready(dec_ready),
        .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] pc; logic live; } fl_t;
    typedef struct packed { logic [15:0] pc; logic [15:0] instr; } rq_t;
    typedef struct packed { logic [15:0] addr; int due; } mem_t;

    fl_t  inflight[$];
    rq_t  ready_q[$];
    mem_t mem_q[$];
    logic [15:0] m_pc;
    logic        m_halted;
    int checks = 0, failures = 0;
    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        inflight.delete();
        ready_q.delete();
        mem_q.delete();
        m_pc = 16'h0000;
        m_halted = 1'b0;
        last_due = 0;
    endtask

    task automatic idle_inputs();
        redirect = 0; redirect_pc = 0; halt = 0; dec_ready = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_dec_valid"}, dec_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_dec_pc"}, dec_pc, 0);
    endtask

    task automatic step(input logic rd, input logic [15:0] rpc, input logic hl,
                        input logic drdy, input logic qrdy);
        logic rsp, stale, e_req, e_dv;
        int live_n, occ, due;
        fl_t f;
        logic [15:0] nxt;
        @(negedge clk);
        redirect = rd; redirect_pc = rpc; halt = hl; dec_ready = drdy; imem_req_ready = qrdy;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mem_q[0].addr) : 16'($urandom);
        #1;
        stale = 0; live_n = 0;
        foreach (inflight[i]) if (inflight[i].live) live_n++; else stale = 1;
        occ   = live_n + ready_q.size();
        e_req = !m_halted && !rd && !hl && (occ < 4) && !stale;
        e_dv  = ready_q.size() > 0;
        nxt   = e_dv ? ready_q[0].pc + 16'd2 : 16'd0;
        chk("req_valid", imem_req_valid, e_req);
        if (e_req) chk("req_addr", imem_req_addr, m_pc);
        chk("dec_valid", dec_valid, e_dv);
        chk("dec_pc", dec_pc, e_dv ? ready_q[0].pc : 16'd0);
        chk("dec_instr", dec_instr, e_dv ? ready_q[0].instr : 16'd0);
        chk("dec_nxt_pc", dec_nxt_pc, nxt);
        chk("count", count, occ);
        chk("halted", halted, m_halted);
        if (e_dv && drdy && !rd) void'(ready_q.pop_front());
        if (rsp) begin
            void'(mem_q.pop_front());
            if (inflight.size() > 0) begin
                f = inflight.pop_front();
                if (f.live && !rd) ready_q.push_back({f.pc, instr_of(f.pc)});
            end
        end
        if (rd) begin
            ready_q.delete();
            foreach (inflight[i]) inflight[i].live = 1'b0;
            m_pc = rpc;
            m_halted = 1'b0;
        end else if (hl) begin
            m_halted = 1'b1;
        end
        if (e_req && qrdy) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mem_q.size() > 0 && due <= last_due) due = last_due + 1;
            last_due = due;
            inflight.push_back({m_pc, 1'b1});
            mem_q.push_back({m_pc, due});
            m_pc = m_pc + 16'd2;
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic drdy, input logic qrdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, drdy, qrdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #1;
        model_clear();
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1;

        // stream, latency 1, decode always ready
        lat_min = 1; lat_max = 1;
        run(12, 1, 1);
        // decode stalled fills exactly DEPTH, then drains in order
        run(8, 0, 1);
        run(10, 1, 1);
        // latency 3, two outstanding, redirect to 0x0040
        do_reset();
        lat_min = 3; lat_max = 3;
        run(2, 0, 1);
        step(1, 16'h0040, 0, 0, 1);
        run(12, 1, 1);
        // halt then resume by redirect
        do_reset();
        lat_min = 1; lat_max = 1;
        run(3, 0, 1);
        step(0, 0, 1, 0, 1);
        run(4, 0, 1);
        run(6, 1, 1);
        step(1, 16'h0010, 1, 1, 1);
        run(8, 1, 1);
        // redirect coinciding with a response and a pop
        lat_min = 2; lat_max = 2;
        run(8, 1, 1);
        step(1, 16'h0200, 0, 1, 1);
        run(10, 1, 1);
        // PC wrap at 0xFFFE
        lat_min = 1; lat_max = 1;
        step(1, 16'hFFFE, 0, 1, 1);
        run(8, 1, 1);
        // mid-operation reset
        lat_min = 1; lat_max = 4;
        run(6, 1, 1);
        do_reset();
        run(6, 1, 1);

        // randomized traffic
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99, 0) < 4,
                 (($urandom_range(99, 0) < 20) ? 16'hFFF8 : 16'($urandom)) & 16'hFFFE,
                 $urandom_range(99, 0) < 3,
                 $urandom_range(99, 0) < 70,
                 $urandom_range(99, 0) < 75);
            if (i % 1000 == 999) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
